// File: rtl/dmem_bram_ctrl.sv
// Data-memory controller: valid/ready request port in front of a synchronous BRAM,
// with byte-lane write enables and load extension. Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
//
// state     | meaning
// S_IDLE    | ready for a request; BRAM driven combinationally in the accept cycle
// S_RD_WAIT | load in flight, counting down the BRAM read latency
// S_RESP    | response pending; rsp_valid pulses on the following cycle
module dmem_bram_ctrl #(
    parameter int  DEPTH_WORDS = 32,
    parameter int  RD_LATENCY  = 1,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_bram_en,
    output logic [3:0]        o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [31:0]       o_bram_din,
    input  logic [31:0]       i_bram_dout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [32:0] C_ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  C_CNT_INIT   = 2'(RD_LATENCY - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_pend_rdata;
    logic        r_pend_err;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_misalign;
    logic        w_err;
    logic [1:0]  w_off;
    logic [3:0]  w_we_mask;
    logic [31:0] w_din;
    logic [31:0] w_rd_shift;
    logic [31:0] w_rd_data;

    assign o_req_ready = (r_state == S_IDLE) && i_rst_n;
    assign w_accept    = i_req_valid && o_req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                        ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // 33-bit compare so the full 32-bit address space is range-checked without wrap
    assign w_err = (i_req_size == SZ_RSVD) || ({1'b0, i_req_addr} >= C_ADDR_LIMIT) || w_misalign;

    // Misaligned halves fall back to lane addr[1]; misaligned words to the aligned-down word
    always_comb begin
        w_off     = 2'b00;
        w_we_mask = 4'b0000;
        w_din     = i_req_wdata;
        case (i_req_size)
            SZ_BYTE: begin
                w_off     = i_req_addr[1:0];
                w_we_mask = 4'b0001 << i_req_addr[1:0];
                w_din     = {4{i_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_off     = {i_req_addr[1], 1'b0};
                w_we_mask = 4'b0011 << {i_req_addr[1], 1'b0};
                w_din     = {2{i_req_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_we_mask = 4'b1111;
            end
            default: ;
        endcase
    end

    assign o_bram_en   = w_accept && !w_err;
    assign o_bram_we   = (o_bram_en && i_req_we) ? w_we_mask : 4'b0000;
    assign o_bram_addr = i_req_addr[ADDR_W+1:2];
    assign o_bram_din  = w_din;

    assign w_rd_shift = i_bram_dout >> {r_off, 3'b000};

    always_comb begin
        w_rd_data = w_rd_shift;
        case (r_size)
            SZ_BYTE: w_rd_data = r_unsigned ? {24'h000000, w_rd_shift[7:0]}
                                            : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            SZ_HALF: w_rd_data = r_unsigned ? {16'h0000, w_rd_shift[15:0]}
                                            : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_rd_data = w_rd_shift;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_off        <= 2'd0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_pend_rdata <= 32'd0;
            r_pend_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_err || i_req_we) begin
                            r_pend_rdata <= 32'd0;
                            r_pend_err   <= w_err;
                            r_state      <= S_RESP;
                        end else begin
                            r_off      <= w_off;
                            r_size     <= i_req_size;
                            r_unsigned <= i_req_unsigned;
                            r_cnt      <= C_CNT_INIT;
                            r_state    <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_pend_rdata <= w_rd_data;
                        r_pend_err   <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Response registers update only when a response is issued, so data/err hold between pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= (r_state == S_RESP);
            if (r_state == S_RESP) begin
                r_rsp_rdata <= r_pend_rdata;
                r_rsp_err   <= r_pend_err;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_bram_ctrl.sv
// Bench for dmem_bram_ctrl: one instance per read latency 1..4, each against a byte-level memory model
// and a timed queue of expected responses.
module tb_dmem_bram_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        logic        err;
        bit          has_lit;
        logic [31:0] lit_data;
        logic        lit_err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_err  = 0;
    int n_done = 0;

    task automatic check(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (RD_LATENCY=%0d): got 0x%08h expected 0x%08h at %0t", name, lat, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_lat
        localparam int LAT = g + 1;

        logic          rst_n;
        logic          req_valid, req_ready, req_we, req_unsigned;
        logic [31:0]   req_addr, req_wdata;
        logic [1:0]    req_size;
        logic          rsp_valid, rsp_err;
        logic [31:0]   rsp_rdata;
        logic          bram_en;
        logic [3:0]    bram_we;
        logic [AW-1:0] bram_addr;
        logic [31:0]   bram_din, bram_dout;

        dmem_bram_ctrl #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)) u_dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_req_valid    (req_valid),
            .o_req_ready    (req_ready),
            .i_req_we       (req_we),
            .i_req_addr     (req_addr),
            .i_req_wdata    (req_wdata),
            .i_req_size     (req_size),
            .i_req_unsigned (req_unsigned),
            .o_rsp_valid    (rsp_valid),
            .o_rsp_rdata    (rsp_rdata),
            .o_rsp_err      (rsp_err),
            .o_bram_en      (bram_en),
            .o_bram_we      (bram_we),
            .o_bram_addr    (bram_addr),
            .o_bram_din     (bram_din),
            .i_bram_dout    (bram_dout)
        );

        // BRAM stand-in: read-first, LAT-cycle output pipeline, garbage when not freshly read
        logic [31:0] bram_mem [DEPTH];
        logic [31:0] pipe [4];
        always @(posedge clk) begin
            if (bram_en) begin
                for (int k = 0; k < 4; k++)
                    if (bram_we[k]) bram_mem[bram_addr][8*k +: 8] <= bram_din[8*k +: 8];
                pipe[0] <= bram_mem[bram_addr];
            end else begin
                pipe[0] <= $urandom;
            end
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign bram_dout = pipe[LAT-1];

        byte unsigned ref_mem [DEPTH*4];
        int unsigned  cyc = 0;
        exp_t         expq [$];
        bit           chk_en;
        logic [31:0]  last_rdata;
        logic         last_err;

        always @(posedge clk) cyc <= cyc + 1;

        function automatic bit is_err(input logic [31:0] a, input logic [1:0] sz);
            bit mis;
            mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
            return (sz == 2'd3) || (a >= 32'(DEPTH*4)) || (TRAP && mis);
        endfunction

        function automatic int nbytes(input logic [1:0] sz);
            return 1 << sz;
        endfunction

        task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input bit uns,
                            input bit has_lit, input logic [31:0] lit_d, input logic lit_e,
                            input bit has_lwe, input logic [3:0] lit_we);
            int   budget, n, fb;
            bit   e;
            logic [3:0]  m;
            logic [31:0] d, v;
            exp_t x;
            budget = 0;
            @(negedge clk);
            while (!req_ready) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
                req_size = 2'($urandom); req_unsigned = 1'($urandom);
                #1 check("bram_en_busy", LAT, 32'(bram_en), 32'd0);
                budget++;
                if (budget > 20) begin
                    n_chk++; n_err++;
                    $display("FAIL ready_timeout (RD_LATENCY=%0d): req_ready stayed 0 for %0d cycles", LAT, budget);
                    return;
                end
                @(negedge clk);
            end
            repeat ($urandom_range(0, 1)) begin
                req_valid = 1'b0;
                @(negedge clk);
            end
            req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
            #1;
            e  = is_err(a, sz);
            n  = nbytes(sz);
            fb = int'(a) & ~(n - 1);
            m  = 4'b0000;
            d  = 32'd0;
            check("bram_en", LAT, 32'(bram_en), 32'(!e));
            if (has_lwe) check("bram_we_lit", LAT, 32'(bram_we), 32'(lit_we));
            if (!e) begin
                for (int i = 0; i < n; i++) m[(fb + i) % 4] = 1'b1;
                check("bram_addr", LAT, 32'(bram_addr), 32'(fb / 4));
                check("bram_we", LAT, 32'(bram_we), we ? 32'(m) : 32'd0);
                if (we) begin
                    for (int k = 0; k < 4; k++) d[8*k +: 8] = wd[8*(k % n) +: 8];
                    check("bram_din", LAT, bram_din, d);
                    for (int i = 0; i < n; i++) ref_mem[fb + i] = wd[8*i +: 8];
                end else begin
                    v = 32'd0;
                    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[fb + i]) << (8 * i));
                    if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
                    if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
                    x.data = v;
                end
            end
            if (e || we) x.data = 32'd0;
            x.err      = e;
            x.due      = (e || we) ? cyc + 2 : cyc + 32'(LAT) + 2;
            x.has_lit  = has_lit;
            x.lit_data = lit_d;
            x.lit_err  = lit_e;
            expq.push_back(x);
            @(posedge clk);
            #1 req_valid = 1'b0;
        endtask

        initial begin
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    if (expq.size() > 0 && expq[0].due == cyc) begin
                        check("rsp_valid", LAT, 32'(rsp_valid), 32'd1);
                        check("rsp_rdata", LAT, rsp_rdata, expq[0].data);
                        check("rsp_err", LAT, 32'(rsp_err), 32'(expq[0].err));
                        if (expq[0].has_lit) begin
                            check("rsp_rdata_lit", LAT, rsp_rdata, expq[0].lit_data);
                            check("rsp_err_lit", LAT, 32'(rsp_err), 32'(expq[0].lit_err));
                        end
                        last_rdata = expq[0].data;
                        last_err   = expq[0].err;
                        void'(expq.pop_front());
                    end else begin
                        check("rsp_valid_quiet", LAT, 32'(rsp_valid), 32'd0);
                        check("rsp_rdata_hold", LAT, rsp_rdata, last_rdata);
                        check("rsp_err_hold", LAT, 32'(rsp_err), 32'(last_err));
                    end
                end
            end
        end

        initial begin
            int          r;
            logic [1:0]  sz;
            logic [31:0] a;
            chk_en = 1'b0; last_rdata = 32'd0; last_err = 1'b0;
            for (int i = 0; i < DEPTH; i++) bram_mem[i] = 32'd0;
            for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'd0;
            rst_n = 1'b0;
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678;
            req_size = 2'd2; req_unsigned = 1'b0;
            repeat (3) @(negedge clk);
            check("ready_in_reset", LAT, 32'(req_ready), 32'd0);
            check("bram_en_in_reset", LAT, 32'(bram_en), 32'd0);
            check("bram_we_in_reset", LAT, 32'(bram_we), 32'd0);
            check("rsp_valid_in_reset", LAT, 32'(rsp_valid), 32'd0);
            check("rsp_rdata_in_reset", LAT, rsp_rdata, 32'd0);
            check("rsp_err_in_reset", LAT, 32'(rsp_err), 32'd0);
            rst_n = 1'b1; req_valid = 1'b0;
            @(negedge clk);
            check("ready_after_reset", LAT, 32'(req_ready), 32'd1);
            chk_en = 1'b1;

            xact(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 4'hF);
            xact(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 4'h0);
            xact(1'b1, 32'h13, 32'h80,       2'd0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 4'b1000);
            xact(1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 4'h0);
            xact(1'b0, 32'h13, 32'h0,        2'd0, 1'b1, 1'b1, 32'h00000080, 1'b0, 1'b0, 4'h0);
            xact(1'b1, 32'h16, 32'h8001,     2'd1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 4'b1100);
            xact(1'b0, 32'h16, 32'h0,        2'd1, 1'b0, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, 4'h0);
            xact(1'b0, 32'h16, 32'h0,        2'd1, 1'b1, 1'b1, 32'h00008001, 1'b0, 1'b0, 4'h0);
            xact(1'b0, 32'h80, 32'h0,        2'd2, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 4'h0);
            xact(1'b0, 32'h0,  32'h0,        2'd3, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 4'h0);
            xact(1'b0, 32'h11, 32'h0,        2'd2, 1'b0, 1'b1,
                 TRAP ? 32'h0 : 32'h80ADBEEF, TRAP, 1'b1, 4'h0);

            // Reset while a load is in flight: the response must vanish
            xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
            chk_en = 1'b0;
            rst_n = 1'b0;
            expq.delete();
            last_rdata = 32'd0; last_err = 1'b0;
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; req_size = 2'd2;
            @(negedge clk);
            check("rsp_valid_mid_reset", LAT, 32'(rsp_valid), 32'd0);
            check("bram_en_mid_reset", LAT, 32'(bram_en), 32'd0);
            check("ready_mid_reset", LAT, 32'(req_ready), 32'd0);
            rst_n = 1'b1; req_valid = 1'b0;
            chk_en = 1'b1;
            @(negedge clk);
            check("ready_after_mid_reset", LAT, 32'(req_ready), 32'd1);
            repeat (LAT + 3) @(negedge clk);

            for (int t = 0; t < 80; t++) begin
                r  = $urandom_range(0, 9);
                sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, DEPTH*4 - 1));
                xact(1'($urandom), a, $urandom, sz, 1'($urandom), 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
            end
            repeat (LAT + 4) @(negedge clk);
            check("queue_drained", LAT, 32'(expq.size()), 32'd0);
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 50000 && n_done < 4; i++) @(posedge clk);
        if (n_done < 4) begin
            n_chk++; n_err++;
            $display("FAIL timeout: finished instances %0d expected 4", n_done);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
